// File: rtl/fetch_decode.sv
// fetch_decode: single-outstanding instruction fetch with capture register and one-hot type decode.
// Revision: 1.0
`default_nettype none

module fetch_decode #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic [6:0]      opcode,
    output logic [5:0]      instruction_type
);

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        VALID = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] fetch_pc_next;
    logic            capture;
    logic            req_state;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
        end
    end

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        capture       = 1'b0;
        req_state     = 1'b0;
        case (state)
            FETCH: begin
                req_state = 1'b1;
                if (imem_ready) begin
                    capture       = 1'b1;
                    state_next    = VALID;
                    fetch_pc_next = fetch_pc + XLEN'(4);
                end
            end
            VALID: begin
                if (!stall) begin
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
        // Redirect overrides everything, including a response arriving this cycle.
        if (redirect_valid) begin
            state_next    = FETCH;
            capture       = 1'b0;
            fetch_pc_next = {redirect_target[XLEN-1:2], 2'b00};
        end
    end

    // Request is gated by reset so it drops the instant reset asserts.
    assign imem_req    = req_state & ~rst_n;
    assign imem_addr   = fetch_pc;
    assign instr_valid = (state == VALID);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            instr <= '0;
            pc    <= '0;
        end else if (capture) begin
            instr <= imem_rdata;
            pc    <= fetch_pc;
        end
    end

    assign opcode = instr[6:0];

    always_comb begin
        instruction_type = 6'b000000;
        if (instr_valid) begin
            case (instr[6:0])
                7'b0110011:                                  instruction_type = 6'b000001;
                7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: instruction_type = 6'b000010;
                7'b0100011:                                  instruction_type = 6'b000100;
                7'b1100011:                                  instruction_type = 6'b001000;
                7'b0110111, 7'b0010111:                      instruction_type = 6'b010000;
                7'b1101111:                                  instruction_type = 6'b100000;
                default:                                     instruction_type = 6'b000000;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_decode.sv
// tb_fetch_decode: directed self-checking bench for fetch_decode (RESET_PC=0 and wrap instance).
// Revision: 1.0
`default_nettype none

module tb_fetch_decode;

    logic        clk = 1'b0;
    logic        rst_a;
    logic        rst_b;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;

    logic        req_a, req_b;
    logic [31:0] addr_a, addr_b;
    logic        vld_a, vld_b;
    logic [31:0] instr_a, instr_b;
    logic [31:0] pc_a, pc_b;
    logic [6:0]  op_a, op_b;
    logic [5:0]  type_a, type_b;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    fetch_decode #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut_a (
        .clk(clk), .rst_n(rst_a),
        .imem_req(req_a), .imem_addr(addr_a),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .instr_valid(vld_a), .instr(instr_a), .pc(pc_a),
        .opcode(op_a), .instruction_type(type_a)
    );

    fetch_decode #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_b (
        .clk(clk), .rst_n(rst_b),
        .imem_req(req_b), .imem_addr(addr_b),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .instr_valid(vld_b), .instr(instr_b), .pc(pc_b),
        .opcode(op_b), .instruction_type(type_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presented instruction: valid, word, pc, type.
    task automatic chk_a(input string tag, input logic v, input logic [31:0] ins,
                         input logic [31:0] p, input logic [5:0] t);
        chk({tag, "_valid"}, {31'd0, vld_a}, {31'd0, v});
        chk({tag, "_instr"}, instr_a, ins);
        chk({tag, "_pc"}, pc_a, p);
        chk({tag, "_type"}, {26'd0, type_a}, {26'd0, t});
    endtask

    task automatic chk_fetch(input string tag, input logic r, input logic [31:0] a);
        chk({tag, "_req"}, {31'd0, req_a}, {31'd0, r});
        chk({tag, "_addr"}, addr_a, a);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        imem_ready = 1'b0; imem_rdata = 32'h0;
        stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
        step(); step();
        chk_a("rst", 1'b0, 32'h0, 32'h0, 6'b000000);
        chk("rst_op", {25'd0, op_a}, 32'h0);
        chk_fetch("rst", 1'b0, 32'h0);

        // Release reset between edges, then fetch R-type at 0.
        rst_a = 1'b0;
        #1;
        chk_fetch("c1", 1'b1, 32'h0);
        imem_ready = 1'b1; imem_rdata = 32'h0000_0033;
        step();
        chk_a("r_cap", 1'b1, 32'h0000_0033, 32'h0, 6'b000001);
        chk("r_op", {25'd0, op_a}, 32'h33);
        chk_fetch("r_cap", 1'b0, 32'h4);
        step();
        chk_a("consume", 1'b0, 32'h0000_0033, 32'h0, 6'b000000);
        chk_fetch("f4", 1'b1, 32'h4);
        imem_rdata = 32'h0000_0013;
        step();
        chk_a("i_cap", 1'b1, 32'h0000_0013, 32'h4, 6'b000010);
        step();
        chk_fetch("f8", 1'b1, 32'h8);

        // Memory not ready for three cycles.
        imem_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_fetch("wait", 1'b1, 32'h8);
            chk("wait_valid", {31'd0, vld_a}, 32'h0);
        end
        imem_ready = 1'b1; imem_rdata = 32'h0000_006F;
        step();
        chk_a("j_cap", 1'b1, 32'h0000_006F, 32'h8, 6'b100000);

        // Stall holds the jal for two cycles.
        stall = 1'b1; imem_rdata = 32'h0000_0033;
        for (int i = 0; i < 2; i++) begin
            step();
            chk_a("stall", 1'b1, 32'h0000_006F, 32'h8, 6'b100000);
            chk_fetch("stall", 1'b0, 32'hC);
        end
        stall = 1'b0;
        step();
        chk_a("unstall", 1'b0, 32'h0000_006F, 32'h8, 6'b000000);
        chk_fetch("unstall", 1'b1, 32'hC);

        // Redirect coincident with ready: response discarded, target aligned.
        redirect_valid = 1'b1; redirect_target = 32'h0000_0103;
        step();
        chk_a("redir", 1'b0, 32'h0000_006F, 32'h8, 6'b000000);
        chk_fetch("redir", 1'b1, 32'h100);
        redirect_valid = 1'b0; imem_rdata = 32'h0000_0023;
        step();
        chk_a("s_cap", 1'b1, 32'h0000_0023, 32'h100, 6'b000100);

        // Redirect in VALID beats a coincident stall.
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_0200;
        step();
        chk("redir_v_valid", {31'd0, vld_a}, 32'h0);
        chk_fetch("redir_v", 1'b1, 32'h200);
        stall = 1'b0; redirect_valid = 1'b0; imem_rdata = 32'h0000_0063;
        step();
        chk_a("b_cap", 1'b1, 32'h0000_0063, 32'h200, 6'b001000);
        imem_rdata = 32'h0000_0037;
        step();
        step();
        chk_a("u_cap", 1'b1, 32'h0000_0037, 32'h204, 6'b010000);
        imem_ready = 1'b0;
        step();
        chk_fetch("pre_rst", 1'b1, 32'h208);

        // Asynchronous reset pulse mid-request.
        rst_a = 1'b1;
        #1;
        chk_fetch("midrst", 1'b0, 32'h0);
        chk_a("midrst", 1'b0, 32'h0, 32'h0, 6'b000000);
        step();
        rst_a = 1'b0;
        #1;
        chk_fetch("restart", 1'b1, 32'h0);

        // Wrap instance: RESET_PC = FFFF_FFFC, unknown opcode.
        chk("b_rst_req", {31'd0, req_b}, 32'h0);
        rst_b = 1'b0;
        #1;
        chk("b_addr", addr_b, 32'hFFFF_FFFC);
        chk("b_req", {31'd0, req_b}, 32'h1);
        imem_ready = 1'b1; imem_rdata = 32'h0000_007F;
        step();
        chk("b_valid", {31'd0, vld_b}, 32'h1);
        chk("b_pc", pc_b, 32'hFFFF_FFFC);
        chk("b_instr", instr_b, 32'h0000_007F);
        chk("b_op", {25'd0, op_b}, 32'h7F);
        chk("b_type", {26'd0, type_b}, 32'h0);
        chk("b_wrap", addr_b, 32'h0);
        step();
        chk("b_next_req", {31'd0, req_b}, 32'h1);
        chk("b_next_addr", addr_b, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_decode.md
Name: fetch_decode

Overview:
- Fetch/decode front end that sits directly upstream of the control unit.
- Holds the fetch PC and issues one instruction-memory request at a time.
- Captures the returned word and presents it with its PC, its 7-bit opcode and a one-hot 6-bit instruction_type; control and the datapath consume these.
- Accepts stalls from downstream and PC redirects from jal/jalr/taken-branch resolution.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- XLEN, 32, address and instruction width.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  reset; asynchronous, active-high (asserted when 1).
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  XLEN  fetch address, word aligned.
- imem_ready  input  1  memory returns data this cycle; sampled only while imem_req=1.
- imem_rdata  input  XLEN  instruction word, valid when imem_req&imem_ready.
- stall  input  1  downstream cannot accept the presented instruction.
- redirect_valid  input  1  load new fetch PC.
- redirect_target  input  XLEN  new fetch PC.
- instr_valid  output  1  instr/pc/opcode/instruction_type are valid.
- instr  output  XLEN  captured instruction word.
- pc  output  XLEN  address the presented instruction was fetched from.
- opcode  output  7  instr[6:0].
- instruction_type  output  6  one-hot: R=000001, I=000010, S=000100, B=001000, U=010000, J=100000, else 000000.

Behaviour:
- Reset (rst_n=1, async):
  - state=FETCH; fetch_pc=RESET_PC.
  - instr_valid=0, instr=0, pc=0, opcode=0, instruction_type=000000.
  - imem_req=0 while reset is held.
- States:
  - FETCH: imem_req=1, imem_addr=fetch_pc.
    - On imem_ready=1: at the edge, instr<=imem_rdata, pc<=fetch_pc, fetch_pc<=fetch_pc+4, instr_valid<=1, go VALID.
    - On imem_ready=0: remain in FETCH; imem_addr is held stable.
  - VALID: imem_req=0; outputs held.
    - stall=0: instruction is consumed at this edge; instr_valid<=0, go FETCH.
    - stall=1: remain in VALID; all outputs held unchanged.
- Throughput: minimum 2 cycles per instruction. Request-to-valid latency is 1 edge after the ready cycle.
- Redirect (redirect_valid=1, highest priority, either state):
  - fetch_pc<=redirect_target with bits [1:0] forced to 0.
  - instr_valid<=0; go FETCH.
  - A coincident imem_ready response is discarded.
  - A coincident stall is ignored.
- Arithmetic: fetch_pc+4 is modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0.
- Decode is combinational from the instr register, so it is stable whenever instr_valid=1:
  - R: opcode 0110011.
  - I: opcodes 0010011, 0000011, 1100111, 1110011.
  - S: opcode 0100011.
  - B: opcode 1100011.
  - U: opcodes 0110111, 0010111.
  - J: opcode 1101111.
  - Any other opcode: 000000.
  - instruction_type is 000000 whenever instr_valid=0.
- Reset mid-request: the request drops immediately. After release, fetch restarts at RESET_PC and any in-flight response is ignored.
- imem_rdata is never sampled when imem_req=0.

Test Plan:
- Reset release, imem_ready=1 every cycle, rdata=32'h00000033 → imem_addr=0 on cycle 1; next cycle instr_valid=1, pc=0, instruction_type=000001; next fetch at 4.
- imem_ready low 3 cycles in FETCH at addr 8 → imem_addr stays 8, instr_valid=0 throughout; data captured on the 4th cycle.
- instr 32'h0000006F (jal) presented, stall=1 for 2 cycles → instr, pc and instruction_type=100000 held; fetch resumes at pc+4 after stall drops.
- redirect_valid=1, target=32'h0000_0103, coincident with imem_ready → response dropped, instr_valid=0, next imem_addr=32'h0000_0100.
- RESET_PC=32'hFFFF_FFFC, one fetch → pc=32'hFFFF_FFFC, next imem_addr=0; an instr with opcode 1111111 → instruction_type=000000.
- rst_n pulsed while in FETCH with imem_ready=0 → imem_req drops immediately, outputs zero; after release, restart at RESET_PC.
